// File: rtl/iiitb_gray_updown_cntr_if.sv
// Control and result bundle for the Gray up/down counter.
// The master drives the count/load controls and the slave returns the registered outputs.
interface iiitb_gray_updown_cntr_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] bin_value;
  logic [WIDTH-1:0] gray_count;
  logic             tc;

  modport master (
    output en, up_dn, load, load_gray,
    input  bin_value, gray_count, tc
  );

  modport slave (
    input  en, up_dn, load, load_gray,
    output bin_value, gray_count, tc
  );
endinterface

// File: rtl/iiitb_gray_updown_cntr.sv
// Parametrised up/down counter with registered binary and Gray outputs, Gray-coded load,
// wrap or saturate at the limits, and a one-cycle terminal-count pulse.
module iiitb_gray_updown_cntr #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  iiitb_gray_updown_cntr_if.slave  bus
);

  localparam logic [WIDTH-1:0] MaxVal = '1;
  localparam logic [WIDTH-1:0] MinVal = '0;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bin_d = gray2bin(bus.load_gray);
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (bin_q == MaxVal) begin
          // At the limit tc fires in both modes; only wrap mode moves the count.
          tc_d  = 1'b1;
          bin_d = SATURATE ? bin_q : MinVal;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == MinVal) begin
          tc_d  = 1'b1;
          bin_d = SATURATE ? bin_q : MaxVal;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
    // Gray is encoded from the next binary value so both outputs leave the same flops edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.bin_value  = bin_q;
  assign bus.gray_count = gray_q;
  assign bus.tc         = tc_q;

endmodule

// File: tb/tb_iiitb_gray_updown_cntr.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter, directed vectors with
// hand-computed expectations, checked by an independent monitor one cycle after each edge.
module tb_iiitb_gray_updown_cntr;

  typedef struct {
    bit         chk;
    bit         onebit;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_w, rst_s;
  int   checks   = 0;
  int   failures = 0;

  exp_t qw[$];
  exp_t qs[$];

  iiitb_gray_updown_cntr_if #(.WIDTH(4)) bw ();
  iiitb_gray_updown_cntr_if #(.WIDTH(4)) bs ();

  iiitb_gray_updown_cntr #(.WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk (clk),
    .rst (rst_w),
    .bus (bw)
  );

  iiitb_gray_updown_cntr #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk (clk),
    .rst (rst_s),
    .bus (bs)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input bit onebit, input logic [3:0] bin, input logic [3:0] gray,
                              input logic tc, input string name);
    exp_t e;
    e.chk = 1'b1; e.onebit = onebit; e.bin = bin; e.gray = gray; e.tc = tc; e.name = name;
    return e;
  endfunction

  function automatic exp_t none();
    exp_t e;
    e.chk = 1'b0; e.onebit = 1'b0; e.bin = '0; e.gray = '0; e.tc = 1'b0; e.name = "";
    return e;
  endfunction

  task automatic set_w(input logic r, input logic en, input logic up, input logic ld,
                       input logic [3:0] lg);
    rst_w = r; bw.en = en; bw.up_dn = up; bw.load = ld; bw.load_gray = lg;
  endtask

  task automatic set_s(input logic r, input logic en, input logic up, input logic ld,
                       input logic [3:0] lg);
    rst_s = r; bs.en = en; bs.up_dn = up; bs.load = ld; bs.load_gray = lg;
  endtask

  // Queue one expectation per DUT for the coming edge, then move to the next negedge.
  task automatic tick(input exp_t ew, input exp_t es);
    qw.push_back(ew);
    qs.push_back(es);
    @(negedge clk);
  endtask

  task automatic cmp(input string dut, input exp_t e, input logic [3:0] bin,
                     input logic [3:0] gray, input logic tc);
    checks++;
    if (bin !== e.bin || gray !== e.gray || tc !== e.tc) begin
      failures++;
      $display("FAIL %s %s: got bin=%h gray=%h tc=%b, expected bin=%h gray=%h tc=%b",
               dut, e.name, bin, gray, tc, e.bin, e.gray, e.tc);
    end
  endtask

  // Monitor: pops one expectation per DUT after every edge.
  initial begin : monitor
    exp_t       e;
    logic [3:0] prev_gray;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (qw.size() > 0) begin
        e = qw.pop_front();
        if (e.chk) cmp("wrap", e, bw.bin_value, bw.gray_count, bw.tc);
        if (e.onebit) begin
          checks++;
          if ($countones(bw.gray_count ^ prev_gray) != 1) begin
            failures++;
            $display("FAIL wrap onebit %s: gray %h -> %h, expected exactly one bit change",
                     e.name, prev_gray, bw.gray_count);
          end
        end
        prev_gray = bw.gray_count;
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        if (e.chk) cmp("sat", e, bs.bin_value, bs.gray_count, bs.tc);
      end
    end
  end

  initial begin : driver
    logic [3:0] up_gray [17];
    int         waited;
    up_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
                4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

    set_w(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    set_s(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);

    // Reset for two edges, then hold with en=0.
    tick(mk(0, 4'h0, 4'h0, 1'b0, "reset1"), mk(0, 4'h0, 4'h0, 1'b0, "reset1"));
    tick(mk(0, 4'h0, 4'h0, 1'b0, "reset2"), mk(0, 4'h0, 4'h0, 1'b0, "reset2"));
    set_w(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    set_s(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    tick(mk(0, 4'h0, 4'h0, 1'b0, "hold1"), mk(0, 4'h0, 4'h0, 1'b0, "hold1"));
    tick(mk(0, 4'h0, 4'h0, 1'b0, "hold2"), mk(0, 4'h0, 4'h0, 1'b0, "hold2"));

    // Wrap DUT counts up 17 edges through the F->0 wrap.
    set_w(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 17; k++) begin
      tick(mk(1, 4'(k % 16), up_gray[k-1], (k == 16), $sformatf("up%0d", k)), none());
    end

    // Gray load of 1100, then count down twice.
    set_w(1'b0, 1'b0, 1'b1, 1'b1, 4'b1100);
    tick(mk(0, 4'h8, 4'hC, 1'b0, "load_C"), none());
    set_w(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    tick(mk(1, 4'h7, 4'h4, 1'b0, "down7"), none());
    tick(mk(1, 4'h6, 4'h5, 1'b0, "down6"), none());

    // Saturate DUT: load E (gray 1001), climb to F, hold with tc, then step back down.
    set_s(1'b0, 1'b0, 1'b1, 1'b1, 4'b1001);
    tick(none(), mk(0, 4'hE, 4'h9, 1'b0, "load_E"));
    set_s(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    tick(none(), mk(0, 4'hF, 4'h8, 1'b0, "reach_F"));
    tick(none(), mk(0, 4'hF, 4'h8, 1'b1, "hold_F1"));
    tick(none(), mk(0, 4'hF, 4'h8, 1'b1, "hold_F2"));
    tick(none(), mk(0, 4'hF, 4'h8, 1'b1, "hold_F3"));
    set_s(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    tick(none(), mk(0, 4'hE, 4'h9, 1'b0, "back_E"));
    set_s(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    tick(none(), mk(0, 4'h1, 4'h1, 1'b0, "load_1"));
    set_s(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    tick(none(), mk(0, 4'h0, 4'h0, 1'b0, "reach_0"));
    tick(none(), mk(0, 4'h0, 4'h0, 1'b1, "hold_01"));
    tick(none(), mk(0, 4'h0, 4'h0, 1'b1, "hold_02"));
    set_s(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick(none(), mk(0, 4'h0, 4'h0, 1'b0, "idle_0"));

    // Wrap DUT: load 0, count to 5, then load 3 with en=1 on the same edge.
    set_w(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    tick(mk(0, 4'h0, 4'h0, 1'b0, "load_0"), none());
    set_w(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      tick(mk(1, 4'(k), up_gray[k-1], 1'b0, $sformatf("to5_%0d", k)), none());
    end
    set_w(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
    tick(mk(0, 4'h2, 4'h3, 1'b0, "load_beats_en"), none());

    // Count 3..9, then reset with en and load asserted.
    set_w(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 3; k <= 9; k++) begin
      tick(mk(1, 4'(k), up_gray[k-1], 1'b0, $sformatf("to9_%0d", k)), none());
    end
    set_w(1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
    tick(mk(0, 4'h0, 4'h0, 1'b0, "rst_over_all"), none());
    set_w(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    tick(mk(1, 4'h1, 4'h1, 1'b0, "resume1"), none());
    tick(mk(1, 4'h2, 4'h3, 1'b0, "resume2"), none());

    // Direction change with no skipped value, then wrap downward through 0.
    set_w(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    tick(mk(1, 4'h1, 4'h1, 1'b0, "dn1"), none());
    tick(mk(1, 4'h0, 4'h0, 1'b0, "dn0"), none());
    tick(mk(1, 4'hF, 4'h8, 1'b1, "wrap_dn"), none());
    tick(mk(1, 4'hE, 4'h9, 1'b0, "dnE"), none());
    set_w(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick(mk(0, 4'hE, 4'h9, 1'b0, "hold_E"), none());

    waited = 0;
    while ((qw.size() > 0 || qs.size() > 0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (qw.size() > 0 || qs.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", qw.size(), qs.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
